// File: rtl/maxpool_reader.sv
// 2x2 stride-2 max pooling reader for one ReLU result map.
// Walks the map window by window through a 1-cycle-latency read port.
module maxpool_reader #(
    parameter int DATA_WIDTH = 45,
    parameter int IN_X       = 24,
    parameter int IN_Y       = 24
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          pool_enable,
    output logic                          rd_en,
    output logic [$clog2(IN_X)-1:0]       rd_row,
    output logic [$clog2(IN_Y)-1:0]       rd_col,
    input  logic [DATA_WIDTH-1:0]         rd_data,
    output logic                          pool_valid,
    output logic [DATA_WIDTH-1:0]         pool_data,
    output logic [$clog2(IN_X/2)-1:0]     pool_row,
    output logic [$clog2(IN_Y/2)-1:0]     pool_col,
    output logic                          busy,
    output logic                          pool_done
);

    localparam int RW  = $clog2(IN_X);
    localparam int CW  = $clog2(IN_Y);
    localparam int PRW = $clog2(IN_X / 2);
    localparam int PCW = $clog2(IN_Y / 2);

    localparam logic [RW-1:0] LAST_ROW = RW'(IN_X - 1);
    localparam logic [CW-1:0] LAST_COL = CW'(IN_Y - 1);

    typedef enum logic [1:0] {
        IDLE,
        READ,
        DRAIN,
        DONE
    } state_t;

    state_t                state;
    logic [1:0]            ph;
    logic                  samp_vld;
    logic [1:0]            samp_ph;
    logic [PRW-1:0]        samp_row;
    logic [PCW-1:0]        samp_col;
    logic [DATA_WIDTH-1:0] mx;
    logic [DATA_WIDTH-1:0] win_max;

    // First sample of a window seeds the running max; later ones compare signed.
    always_comb begin
        win_max = mx;
        if (samp_ph == 2'd0 || $signed(rd_data) > $signed(mx)) begin
            win_max = rd_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            ph         <= '0;
            rd_en      <= 1'b0;
            rd_row     <= '0;
            rd_col     <= '0;
            samp_vld   <= 1'b0;
            samp_ph    <= '0;
            samp_row   <= '0;
            samp_col   <= '0;
            mx         <= '0;
            pool_valid <= 1'b0;
            pool_data  <= '0;
            pool_row   <= '0;
            pool_col   <= '0;
            busy       <= 1'b0;
            pool_done  <= 1'b0;
        end else begin
            pool_valid <= 1'b0;
            samp_vld   <= rd_en;
            samp_ph    <= ph;
            samp_row   <= rd_row[RW-1:1];
            samp_col   <= rd_col[CW-1:1];

            if (samp_vld) begin
                mx <= win_max;
                if (samp_ph == 2'd3) begin
                    pool_valid <= 1'b1;
                    pool_data  <= win_max;
                    pool_row   <= samp_row;
                    pool_col   <= samp_col;
                end
            end

            unique case (state)
                IDLE: begin
                    if (pool_enable) begin
                        state  <= READ;
                        rd_en  <= 1'b1;
                        rd_row <= '0;
                        rd_col <= '0;
                        ph     <= '0;
                        busy   <= 1'b1;
                    end
                end
                READ: begin
                    ph <= ph + 2'd1;
                    if (ph == 2'd3 && rd_row == LAST_ROW && rd_col == LAST_COL) begin
                        rd_en <= 1'b0;
                        state <= DRAIN;
                    end else begin
                        // Z-walk inside a window, then hop to the next window.
                        unique case (ph)
                            2'd0: rd_col <= rd_col + CW'(1);
                            2'd1: begin
                                rd_row <= rd_row + RW'(1);
                                rd_col <= rd_col - CW'(1);
                            end
                            2'd2: rd_col <= rd_col + CW'(1);
                            2'd3: begin
                                if (rd_col == LAST_COL) begin
                                    rd_row <= rd_row + RW'(1);
                                    rd_col <= '0;
                                end else begin
                                    rd_row <= rd_row - RW'(1);
                                    rd_col <= rd_col + CW'(1);
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                DRAIN: begin
                    if (pool_valid) begin
                        state     <= DONE;
                        pool_done <= 1'b1;
                    end
                end
                DONE: begin
                    state     <= IDLE;
                    pool_done <= 1'b0;
                    busy      <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_maxpool_reader.sv
// Randomized and directed bench for maxpool_reader against a
// cycle-indexed reference built from window arithmetic.
module tb_maxpool_reader;

    localparam int DW = 45;
    localparam int NX = 24;
    localparam int NY = 24;
    localparam int NW = (NX / 2) * (NY / 2);
    localparam int NA = NX * NY;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          pool_enable = 1'b0;
    logic          rd_en;
    logic [4:0]    rd_row;
    logic [4:0]    rd_col;
    logic [DW-1:0] rd_data;
    logic          pool_valid;
    logic [DW-1:0] pool_data;
    logic [3:0]    pool_row;
    logic [3:0]    pool_col;
    logic          busy;
    logic          pool_done;

    logic [DW-1:0] mem [NX][NY];
    logic [DW-1:0] last_data;
    int            last_row;
    int            last_col;
    int            n_chk = 0;
    int            n_fail = 0;

    maxpool_reader #(
        .DATA_WIDTH(DW),
        .IN_X(NX),
        .IN_Y(NY)
    ) dut (
        .clk(clk),
        .rst(rst),
        .pool_enable(pool_enable),
        .rd_en(rd_en),
        .rd_row(rd_row),
        .rd_col(rd_col),
        .rd_data(rd_data),
        .pool_valid(pool_valid),
        .pool_data(pool_data),
        .pool_row(pool_row),
        .pool_col(pool_col),
        .busy(busy),
        .pool_done(pool_done)
    );

    always #5 clk = ~clk;

    // Result storage with one cycle of read latency.
    always @(posedge clk) begin
        if (rst) rd_data <= '0;
        else if (rd_en) rd_data <= mem[rd_row][rd_col];
    end

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] wmax(input int pr, input int pc);
        logic signed [DW-1:0] m;
        m = mem[2*pr][2*pc];
        for (int dr = 0; dr < 2; dr++)
            for (int dc = 0; dc < 2; dc++)
                if ($signed(mem[2*pr+dr][2*pc+dc]) > m) m = mem[2*pr+dr][2*pc+dc];
        return m;
    endfunction

    task automatic check_cycle(input int t);
        bit act, v;
        int k, p;
        act = (t >= 1 && t <= NA);
        chk("rd_en", rd_en, act);
        if (act) begin
            k = (t - 1) / 4;
            p = (t - 1) % 4;
            chk("rd_row", rd_row, 2 * (k / (NY/2)) + p / 2);
            chk("rd_col", rd_col, 2 * (k % (NY/2)) + p % 2);
        end
        v = (t >= 6 && t <= NA + 2 && (t - 6) % 4 == 0);
        if (v) begin
            k = (t - 6) / 4;
            last_row  = k / (NY/2);
            last_col  = k % (NY/2);
            last_data = wmax(last_row, last_col);
        end
        chk("pool_valid", pool_valid, v);
        chk("pool_data", pool_data, last_data);
        chk("pool_row", pool_row, last_row);
        chk("pool_col", pool_col, last_col);
        chk("busy", busy, t >= 1 && t <= NA + 3);
        chk("pool_done", pool_done, t == NA + 3);
    endtask

    task automatic check_idle_zero(input string tag);
        chk({tag, "_rd_en"}, rd_en, 0);
        chk({tag, "_rd_row"}, rd_row, 0);
        chk({tag, "_rd_col"}, rd_col, 0);
        chk({tag, "_pool_valid"}, pool_valid, 0);
        chk({tag, "_pool_data"}, pool_data, 0);
        chk({tag, "_pool_row"}, pool_row, 0);
        chk({tag, "_pool_col"}, pool_col, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_pool_done"}, pool_done, 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        pool_enable = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_idle_zero("reset");
        rst = 1'b0;
        last_data = '0;
        last_row = 0;
        last_col = 0;
    endtask

    // reassert_at / abort_at = 0 disables the respective event.
    task automatic run(input int reassert_at, input int abort_at);
        @(negedge clk);
        pool_enable = 1'b1;
        for (int t = 1; t <= NA + 4; t++) begin
            @(negedge clk);
            if (abort_at != 0 && t == abort_at + 1) begin
                check_idle_zero("abort");
                rst = 1'b0;
                last_data = '0;
                last_row = 0;
                last_col = 0;
                for (int i = 0; i < 6; i++) begin
                    @(negedge clk);
                    check_idle_zero("post_abort");
                end
                return;
            end
            check_cycle(t);
            if (t == 1) pool_enable = 1'b0;
            if (reassert_at != 0 && t == reassert_at) pool_enable = 1'b1;
            if (reassert_at != 0 && t == reassert_at + 1) pool_enable = 1'b0;
            if (abort_at != 0 && t == abort_at) rst = 1'b1;
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("idle_busy", busy, 0);
            chk("idle_done", pool_done, 0);
            chk("idle_valid", pool_valid, 0);
        end
    endtask

    task automatic fill_random();
        logic [63:0] r;
        for (int i = 0; i < NX; i++)
            for (int j = 0; j < NY; j++) begin
                r = {$urandom, $urandom};
                mem[i][j] = r[DW-1:0];
            end
    endtask

    initial begin
        for (int i = 0; i < NX; i++)
            for (int j = 0; j < NY; j++) mem[i][j] = '0;

        do_reset();
        run(0, 0);

        for (int i = 0; i < NX; i++)
            for (int j = 0; j < NY; j++) mem[i][j] = DW'(i * NY + j);
        run(0, 0);

        for (int k = 0; k < NW; k++) begin
            int pr, pc, p;
            pr = k / (NY/2);
            pc = k % (NY/2);
            p  = k % 4;
            for (int d = 0; d < 4; d++)
                mem[2*pr + d/2][2*pc + d%2] = (d == p) ? 45'h0fedcba98765 : 45'd1;
        end
        run(0, 0);

        fill_random();
        mem[0][0] = 45'h1fedcba98765;
        mem[0][1] = 45'h000000000003;
        mem[1][0] = 45'h1ffffffffffb;
        mem[1][1] = 45'h1ffffffffff9;
        mem[0][2] = 45'h1fffffffffff;
        mem[0][3] = 45'h1ffffffffffe;
        mem[1][2] = 45'h1ffffffffffd;
        mem[1][3] = 45'h1ffffffffffc;
        run(100, 0);

        fill_random();
        run(0, 50);
        fill_random();
        run(0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/maxpool_reader.md
Name: maxpool_reader

Overview:
- Consumer of one ReLU channel's result map (IN_X x IN_Y signed words) once the ReLU layer signals completion.
- Reads the map through a 1-cycle-latency read port and performs 2x2, stride-2 max pooling.
- Streams out (IN_X/2) x (IN_Y/2) pooled words with row/col tags and a done pulse.
- Instantiated once per channel (8 in the current network) behind relu_layer; pool_enable is driven from relu_done.

Parameters:
- DATA_WIDTH, 45, width of each ReLU result word (two's complement).
- IN_X, 24, input rows; must be even.
- IN_Y, 24, input columns; must be even.

Ports:
- clk  input  1  clock, all logic on rising edge
- rst  input  1  synchronous reset, active-high
- pool_enable  input  1  start request, sampled only in IDLE
- rd_en  output  1  read strobe to ReLU result storage
- rd_row  output  $clog2(IN_X)  read row address
- rd_col  output  $clog2(IN_Y)  read column address
- rd_data  input  DATA_WIDTH  read data, valid the cycle after rd_en
- pool_valid  output  1  pool_data/pool_row/pool_col valid this cycle
- pool_data  output  DATA_WIDTH  max of one 2x2 window
- pool_row  output  $clog2(IN_X/2)  output row index
- pool_col  output  $clog2(IN_Y/2)  output column index
- busy  output  1  high in any state except IDLE
- pool_done  output  1  one-cycle pulse after last pooled word

Behaviour:
- Reset: synchronous, active-high. State=IDLE; rd_en, pool_valid, busy, pool_done = 0; rd_row, rd_col, pool_data, pool_row, pool_col = 0. Applies mid-operation: window aborted, no pool_done, no further pool_valid.
- FSM: IDLE -> READ when pool_enable=1 (cycle 0). READ -> DRAIN after the last address is issued. DRAIN -> DONE once the last pool_valid has been emitted. DONE -> IDLE unconditionally.
- pool_enable is ignored outside IDLE. If pool_enable is high in IDLE, a new run starts, so back-to-back runs are allowed.
- READ issues exactly one address per cycle with rd_en=1, for IN_X*IN_Y cycles (576 by default), in cycles 1..576.
- Window order is row-major over output coordinates: window k = (pr, pc), k = pr*(IN_Y/2) + pc.
- Address order within window k, in cycles 4k+1..4k+4: (2pr, 2pc), (2pr, 2pc+1), (2pr+1, 2pc), (2pr+1, 2pc+1).
- rd_data is captured in the cycle after each rd_en. The running max is initialised by the first sample of each window, not by 0.
- Compare is signed (two's complement), so negative inputs pool correctly. On ties, either equal value is output.
- pool_valid for window k is registered high in cycle 4k+6, together with pool_data = max, pool_row = pr, pool_col = pc. Otherwise pool_valid = 0, and pool_data/row/col hold their last values.
- Last window (k = 143): pool_valid in cycle 578. pool_done = 1 in cycle 579 (DONE state), then IDLE in cycle 580 with busy = 0.
- busy = 1 from cycle 1 through cycle 579 inclusive.
- No backpressure: the downstream block must accept one pool_valid every 4 cycles.
- Widths: no truncation; pool_data is a full DATA_WIDTH copy of an input word.

Test Plan:
- Reset, then pool_enable=1 for 1 cycle with all inputs = 45'h0 -> 144 pool_valid pulses, 4 cycles apart, first in cycle 6, all pool_data = 0, pool_done only in cycle 579.
- Input value at (r,c) = r*24 + c -> window (pr,pc) outputs (2pr+1)*24 + 2pc+1; e.g. (0,0) = 25, (11,11) = 575; pool_row/pool_col match.
- Max placed in each of the 4 window positions in turn (value 45'h0fedcba98765, others 1) -> output 45'h0fedcba98765 for every placement.
- Window holding 45'h1fedcba98765 (negative) and 45'h000000000003 -> 3. Window of all negative values -1,-2,-3,-4 -> 45'h1fffffffffff.
- pool_enable re-asserted at cycle 100 -> ignored: address sequence unbroken, 144 outputs, single pool_done.
- rst=1 at cycle 50 -> next cycle all outputs 0, state IDLE, no pool_done. A fresh pool_enable then gives a full correct run.
